// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit period.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    // 100 MHz system clock at 115200 baud.
    localparam int DEFAULT_CYCLES_PER_BIT = 868;

endpackage

// File: rtl/synchronizer2.sv
// Two-flop bit synchronizer for asynchronous inputs, with a selectable reset value.
module synchronizer2 #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling of the synchronized line, one-cycle byte and
// framing-error strobes, and a BREAK state that ignores a held-low line.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           rxd,
    output logic           rx_ready,
    output logic [7:0]     rdata,
    output logic           ferr,
    output logic           busy,
    output uart_rx_state_t state
);

    localparam int CNT_W = $clog2(CYCLES_PER_BIT);
    // Counters count down to zero, so loads are one less than the interval.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CYCLES_PER_BIT - 1);

    generate
        if (CYCLES_PER_BIT < 4) begin : g_bad_cycles_per_bit
            $error("uart_receiver: CYCLES_PER_BIT must be >= 4");
        end
    endgenerate

    logic rxs;
    logic rxs_prev;

    synchronizer2 #(
        .RESET_VALUE (1'b1)
    ) u_rxd_sync (
        .clock (clock),
        .reset (reset),
        .d     (rxd),
        .q     (rxs)
    );

    uart_rx_state_t   state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [2:0]       bit_q, bit_n;
    logic [7:0]       shift_q, shift_n;
    logic [7:0]       rdata_q, rdata_n;
    logic             rx_ready_q, rx_ready_n;
    logic             ferr_q, ferr_n;
    logic             busy_q, busy_n;
    logic             cnt_zero;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rdata_q    <= '0;
            rx_ready_q <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
            rxs_prev   <= 1'b1;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            bit_q      <= bit_n;
            shift_q    <= shift_n;
            rdata_q    <= rdata_n;
            rx_ready_q <= rx_ready_n;
            ferr_q     <= ferr_n;
            busy_q     <= busy_n;
            rxs_prev   <= rxs;
        end
    end

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        bit_n      = bit_q;
        shift_n    = shift_q;
        rdata_n    = rdata_q;
        rx_ready_n = 1'b0;
        ferr_n     = 1'b0;
        busy_n     = busy_q;

        case (state_q)
            IDLE: begin
                if (rxs_prev && !rxs) begin
                    cnt_n   = HALF_LOAD;
                    state_n = START;
                end
            end

            START: begin
                if (!cnt_zero) begin
                    cnt_n = cnt_q - CNT_W'(1);
                end else if (!rxs) begin
                    busy_n  = 1'b1;
                    bit_n   = '0;
                    cnt_n   = BIT_LOAD;
                    state_n = DATA;
                end else begin
                    // Line back high at mid start bit: treat as a glitch.
                    state_n = IDLE;
                end
            end

            DATA: begin
                if (!cnt_zero) begin
                    cnt_n = cnt_q - CNT_W'(1);
                end else begin
                    shift_n = {rxs, shift_q[7:1]};
                    cnt_n   = BIT_LOAD;
                    if (bit_q == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_n = bit_q + 3'd1;
                    end
                end
            end

            STOP: begin
                if (!cnt_zero) begin
                    cnt_n = cnt_q - CNT_W'(1);
                end else begin
                    busy_n = 1'b0;
                    if (rxs) begin
                        rdata_n    = shift_q;
                        rx_ready_n = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end
            end

            BREAK: begin
                // A held-low line must go high before a new start edge can count.
                if (rxs) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign rx_ready = rx_ready_q;
    assign rdata    = rdata_q;
    assign ferr     = ferr_q;
    assign busy     = busy_q;
    assign state    = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at 16 cycles/bit: frames are driven bit by bit and the
// received bytes and strobe timing are compared against what was sent.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int B = 16;
    localparam int H = B / 2;
    // Pin change to rx_ready: 2 sync cycles + H + 9 bits + 1 registered cycle.
    localparam int STROBE_LAT = 2 + H + 9 * B + 1;

    logic           clock;
    logic           reset;
    logic           rxd;
    logic           rx_ready;
    logic [7:0]     rdata;
    logic           ferr;
    logic           busy;
    uart_rx_state_t state;

    uart_receiver #(
        .CYCLES_PER_BIT (B)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rxd      (rxd),
        .rx_ready (rx_ready),
        .rdata    (rdata),
        .ferr     (ferr),
        .busy     (busy),
        .state    (state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         passes = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_cyc_q[$];
    int         ferr_cnt;
    int         both_cnt = 0;
    logic [7:0] ferr_rdata;
    logic       busy_seen;
    logic [7:0] last_good;
    int         last_edge_cyc;

    always @(negedge clock) begin
        if (reset) begin
            if (rx_ready) begin
                got_q.push_back(rdata);
                got_cyc_q.push_back(cyc);
            end
            if (ferr) begin
                ferr_cnt   = ferr_cnt + 1;
                ferr_rdata = rdata;
            end
            if (rx_ready && ferr) both_cnt = both_cnt + 1;
            if (busy) busy_seen = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_obs();
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
        ferr_cnt  = 0;
        busy_seen = 1'b0;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    // Called at a negedge; returns at a negedge so frames can abut.
    task automatic send_frame(input logic [7:0] data, input int cpb, input logic stop_bit);
        rxd = 1'b0;
        last_edge_cyc = cyc;
        repeat (cpb) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (cpb) @(negedge clock);
        end
        rxd = stop_bit;
        repeat (cpb) @(negedge clock);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        rxd   = 1'b1;
        repeat (5) @(negedge clock);
        checks++; if (rx_ready !== 1'b0) $display("FAIL reset_rx_ready: got %b expected 0", rx_ready); else passes++;
        checks++; if (ferr !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", ferr); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if (rdata !== 8'h00) $display("FAIL reset_rdata: got %h expected 00", rdata); else passes++;
        checks++; if (state !== IDLE) $display("FAIL reset_state: got %0d expected %0d", state, IDLE); else passes++;
        reset = 1'b1;
        idle(10);
    endtask

    task automatic test_single();
        int exp_cyc;
        clear_obs();
        exp_q.push_back(8'h99);
        send_frame(8'h99, B, 1'b1);
        exp_cyc = last_edge_cyc + STROBE_LAT;
        idle(30);
        checks++; if (got_q.size() !== 1) $display("FAIL single_count: got %0d expected 1", got_q.size()); else passes++;
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0] !== exp_q[0]) $display("FAIL single_data: got %h expected %h", got_q[0], exp_q[0]); else passes++;
            checks++; if (got_cyc_q[0] !== exp_cyc) $display("FAIL single_timing: got cycle %0d expected %0d", got_cyc_q[0], exp_cyc); else passes++;
        end
        checks++; if (ferr_cnt !== 0) $display("FAIL single_ferr: got %0d expected 0", ferr_cnt); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL single_busy_idle: got %b expected 0", busy); else passes++;
        last_good = 8'h99;
    endtask

    task automatic test_back_to_back();
        int first_edge;
        clear_obs();
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < 4; i++) begin
            send_frame(exp_q[i], B, 1'b1);
            if (i == 0) first_edge = last_edge_cyc;
        end
        idle(30);
        checks++; if (got_q.size() !== 4) $display("FAIL b2b_count: got %0d expected 4", got_q.size()); else passes++;
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("FAIL b2b_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); else passes++;
        end
        for (int i = 1; i < got_cyc_q.size(); i++) begin
            checks++;
            if (got_cyc_q[i] - got_cyc_q[i-1] !== 10 * B)
                $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, got_cyc_q[i] - got_cyc_q[i-1], 10 * B);
            else passes++;
        end
        if (got_cyc_q.size() >= 1) begin
            checks++; if (got_cyc_q[0] !== first_edge + STROBE_LAT) $display("FAIL b2b_first_timing: got %0d expected %0d", got_cyc_q[0], first_edge + STROBE_LAT); else passes++;
        end
        last_good = 8'h04;
    endtask

    task automatic test_glitch();
        clear_obs();
        rxd = 1'b0;
        repeat (4) @(negedge clock);
        idle(40);
        checks++; if (got_q.size() !== 0) $display("FAIL glitch_no_strobe: got %0d expected 0", got_q.size()); else passes++;
        checks++; if (busy_seen !== 1'b0) $display("FAIL glitch_busy: got %b expected 0", busy_seen); else passes++;
        checks++; if (ferr_cnt !== 0) $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt); else passes++;
        checks++; if (state !== IDLE) $display("FAIL glitch_state: got %0d expected %0d", state, IDLE); else passes++;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, B, 1'b1);
        idle(30);
        checks++; if (got_q.size() !== 1) $display("FAIL glitch_follow_count: got %0d expected 1", got_q.size()); else passes++;
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0] !== exp_q[0]) $display("FAIL glitch_follow_data: got %h expected %h", got_q[0], exp_q[0]); else passes++;
        end
        last_good = 8'h5A;
    endtask

    task automatic test_break();
        clear_obs();
        send_frame(8'hAA, B, 1'b0);
        busy_seen = 1'b0;
        repeat (24) @(negedge clock);
        checks++; if (state !== BREAK) $display("FAIL break_state: got %0d expected %0d", state, BREAK); else passes++;
        repeat (24) @(negedge clock);
        idle(30);
        checks++; if (ferr_cnt !== 1) $display("FAIL break_ferr_count: got %0d expected 1", ferr_cnt); else passes++;
        checks++; if (ferr_rdata !== last_good) $display("FAIL break_rdata_at_ferr: got %h expected %h", ferr_rdata, last_good); else passes++;
        checks++; if (rdata !== last_good) $display("FAIL break_rdata_kept: got %h expected %h", rdata, last_good); else passes++;
        checks++; if (got_q.size() !== 0) $display("FAIL break_no_strobe: got %0d expected 0", got_q.size()); else passes++;
        checks++; if (busy_seen !== 1'b0) $display("FAIL break_no_start: got busy %b expected 0", busy_seen); else passes++;
        exp_q.push_back(8'h55);
        send_frame(8'h55, B, 1'b1);
        idle(30);
        checks++; if (got_q.size() !== 1) $display("FAIL break_follow_count: got %0d expected 1", got_q.size()); else passes++;
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0] !== exp_q[0]) $display("FAIL break_follow_data: got %h expected %h", got_q[0], exp_q[0]); else passes++;
        end
        last_good = 8'h55;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] frame;
        clear_obs();
        frame = 8'h7E;
        rxd = 1'b0;
        repeat (B) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            rxd = frame[i];
            repeat (B) @(negedge clock);
        end
        rxd = frame[3];
        repeat (H) @(negedge clock);
        checks++; if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b expected 1", busy); else passes++;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else passes++;
        checks++; if (rdata !== 8'h00) $display("FAIL midrst_rdata: got %h expected 00", rdata); else passes++;
        checks++; if (rx_ready !== 1'b0) $display("FAIL midrst_rx_ready: got %b expected 0", rx_ready); else passes++;
        checks++; if (ferr !== 1'b0) $display("FAIL midrst_ferr: got %b expected 0", ferr); else passes++;
        checks++; if (state !== IDLE) $display("FAIL midrst_state: got %0d expected %0d", state, IDLE); else passes++;
        @(negedge clock);
        rxd = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        idle(20);
        clear_obs();
        exp_q.push_back(8'h12);
        send_frame(8'h12, B, 1'b1);
        idle(30);
        checks++; if (got_q.size() !== 1) $display("FAIL midrst_follow_count: got %0d expected 1", got_q.size()); else passes++;
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0] !== exp_q[0]) $display("FAIL midrst_follow_data: got %h expected %h", got_q[0], exp_q[0]); else passes++;
        end
        last_good = 8'h12;
    endtask

    task automatic test_baud_mismatch();
        clear_obs();
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, B + 1, 1'b1);
        idle(40);
        send_frame(8'hC3, B - 1, 1'b1);
        idle(40);
        checks++; if (got_q.size() !== 2) $display("FAIL baud_count: got %0d expected 2", got_q.size()); else passes++;
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("FAIL baud_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); else passes++;
        end
        checks++; if (ferr_cnt !== 0) $display("FAIL baud_ferr: got %0d expected 0", ferr_cnt); else passes++;
        last_good = 8'hC3;
    endtask

    task automatic test_random();
        logic [7:0] b;
        clear_obs();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, B, 1'b1);
            idle($urandom_range(0, 12));
        end
        idle(30);
        checks++; if (got_q.size() !== exp_q.size()) $display("FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size()); else passes++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("FAIL random_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); else passes++;
        end
        checks++; if (ferr_cnt !== 0) $display("FAIL random_ferr: got %0d expected 0", ferr_cnt); else passes++;
        checks++; if (both_cnt !== 0) $display("FAIL strobe_exclusive: got %0d overlaps expected 0", both_cnt); else passes++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rxd   = 1'b1;
        reset = 1'b0;
        ferr_cnt  = 0;
        busy_seen = 1'b0;
        last_good = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_mid_frame();
        test_baud_mismatch();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
